// File: rtl/vdp_palette_pkg.sv
// Shared types and constants for the VDP palette port writer.
//   phase_e      : byte phase of the palette data port (PH0/PH1/PH2)
//   LEGACY_*     : size of the 16-entry, 2-byte-per-entry palette
//   pal_entry_t  : one committed palette entry {index, r, g, b}; fields are
//                  sized for the widest legal parameters and are
//                  right-justified (upper bits zero) for narrower ones.
//   rep3_bit     : bit k (counted from the MSB) of a 3-bit value repeated
//                  end-to-end; used to widen legacy 3-bit colour components.
package vdp_palette_pkg;

    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2
    } phase_e;

    localparam int unsigned LEGACY_ENTRIES = 16;
    localparam int unsigned LEGACY_INDEX_W = $clog2(LEGACY_ENTRIES);

    localparam int unsigned MAX_INDEX_W = 8;
    localparam int unsigned MAX_COMP_W  = 8;

    typedef struct packed {
        logic [MAX_INDEX_W-1:0] index;
        logic [MAX_COMP_W-1:0]  r;
        logic [MAX_COMP_W-1:0]  g;
        logic [MAX_COMP_W-1:0]  b;
    } pal_entry_t;

    // Repeating the 3-bit pattern v2 v1 v0 v2 v1 ... left-justifies the value
    // and fills the low bits with copies of its MSBs.
    function automatic logic rep3_bit(input logic [2:0] v, input int k);
        logic bit_val;
        case (k % 3)
            0:       bit_val = v[2];
            1:       bit_val = v[1];
            default: bit_val = v[0];
        endcase
        return bit_val;
    endfunction

endpackage

// File: rtl/vdp_palette_if.sv
// Palette RAM write stream between the palette writer and the palette RAM.
//   pal_valid : entry available (writer -> RAM)
//   pal_ready : RAM accepts the entry (RAM -> writer)
//   pal_addr  : entry index, INDEX_W bits
//   pal_r/g/b : colour components, COMP_W bits each
// An entry transfers on a clock edge where pal_valid && pal_ready.
interface vdp_palette_if #(
    parameter int COMP_W  = 5,
    parameter int INDEX_W = 8
);
    logic               pal_valid;
    logic               pal_ready;
    logic [INDEX_W-1:0] pal_addr;
    logic [COMP_W-1:0]  pal_r;
    logic [COMP_W-1:0]  pal_g;
    logic [COMP_W-1:0]  pal_b;

    modport master (
        output pal_valid, pal_addr, pal_r, pal_g, pal_b,
        input  pal_ready
    );

    modport slave (
        input  pal_valid, pal_addr, pal_r, pal_g, pal_b,
        output pal_ready
    );
endinterface

// File: rtl/vdp_palette_fifo.sv
// Two-entry FIFO that decouples palette commits from the palette RAM.
//   clk, reset_n : clock, synchronous active-low reset
//   push, din    : write an entry (ignored while full unless the head leaves
//                  in the same cycle)
//   pop_ready    : consumer accepts the head this cycle if valid
//   valid, dout  : head entry
//   full         : both slots occupied
module vdp_palette_fifo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop_ready,
    output logic             valid,
    output logic             full,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count;
    logic             pop;
    logic             push_ok;

    assign valid   = (count != 2'd0);
    assign full    = (count == 2'd2);
    assign pop     = valid && pop_ready;
    // A full FIFO still takes a new entry when its head leaves this cycle;
    // the new entry lands in the slot being vacated.
    assign push_ok = push && (!full || pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples the pre-edge values of its inputs.
        if (!reset_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            // NOTE: the storage is only two words and the head is visible on
            // the outputs, so it is cleared to make the outputs read zero.
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vdp_palette_writer.sv
// VDP palette port writer: assembles palette entries from the byte-wide
// palette data port and streams them to the palette RAM.
//   clk, reset_n   : clock, synchronous active-low reset
//   palette_mode   : 0 = 16-entry 2-byte entries, 1 = full 3-byte entries
//   index_set      : strobe, load index from index_data and restart the entry
//   index_data     : new palette index (low INDEX_W bits used)
//   wr_en, wdata   : strobe + palette data byte
//   overflow       : sticky, an entry was dropped because the FIFO was full;
//                    cleared by index_set or reset
//   pal            : palette RAM write stream (master side)
module vdp_palette_writer
    import vdp_palette_pkg::*;
#(
    parameter int COMP_W  = 5,
    parameter int INDEX_W = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                palette_mode,
    input  logic                index_set,
    input  logic [7:0]          index_data,
    input  logic                wr_en,
    input  logic [7:0]          wdata,
    output logic                overflow,
    vdp_palette_if.master       pal
);

    // Widen a 3-bit legacy component to COMP_W bits.
    function automatic logic [COMP_W-1:0] expand3(input logic [2:0] v);
        logic [COMP_W-1:0] res;
        for (int i = 0; i < COMP_W; i++) begin
            res[i] = rep3_bit(v, COMP_W - 1 - i);
        end
        return res;
    endfunction

    // Full-mode component: the top COMP_W bits of the data byte.
    function automatic logic [COMP_W-1:0] top_bits(input logic [7:0] d);
        return d[7 -: COMP_W];
    endfunction

    phase_e                      phase_q, phase_d;
    logic [INDEX_W-1:0]          index_q, index_d;
    logic [COMP_W-1:0]           r_q, r_d;
    logic [COMP_W-1:0]           g_q, g_d;
    logic [COMP_W-1:0]           b_q, b_d;
    logic                        overflow_q, overflow_d;
    logic                        mode_q;

    logic                        mode_changed;
    phase_e                      eff_phase;
    logic                        commit;
    pal_entry_t                  commit_entry;
    logic [INDEX_W-1:0]          commit_addr;
    logic [INDEX_W-1:0]          next_index;
    logic [LEGACY_INDEX_W-1:0]   legacy_next;

    logic                        fifo_valid;
    logic                        fifo_full;
    pal_entry_t                  head;
    logic                        xfer;

    assign xfer = fifo_valid && pal.pal_ready;

    // Legacy mode addresses only the low 16 entries and wraps within them.
    assign legacy_next = index_q[LEGACY_INDEX_W-1:0] + LEGACY_INDEX_W'(1);
    assign commit_addr = palette_mode ? index_q
                                      : INDEX_W'(index_q[LEGACY_INDEX_W-1:0]);
    assign next_index  = palette_mode ? index_q + INDEX_W'(1)
                                      : INDEX_W'(legacy_next);

    // A mode switch restarts the entry; a byte arriving in the same cycle is
    // taken as the first byte of the new mode.
    assign mode_changed = (palette_mode != mode_q);
    assign eff_phase    = mode_changed ? PH0 : phase_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        phase_d      = mode_changed ? PH0 : phase_q;
        index_d      = index_q;
        r_d          = r_q;
        g_d          = g_q;
        b_d          = b_q;
        overflow_d   = overflow_q;
        commit       = 1'b0;
        commit_entry = '0;

        if (index_set) begin
            // index_set wins over a simultaneous data byte.
            index_d    = index_data[INDEX_W-1:0];
            phase_d    = PH0;
            overflow_d = 1'b0;
        end else if (wr_en) begin
            if (!palette_mode) begin
                case (eff_phase)
                    PH0: begin
                        r_d     = expand3(wdata[6:4]);
                        b_d     = expand3(wdata[2:0]);
                        phase_d = PH1;
                    end
                    default: begin
                        commit  = 1'b1;
                        phase_d = PH0;
                    end
                endcase
            end else begin
                case (eff_phase)
                    PH0: begin
                        r_d     = top_bits(wdata);
                        phase_d = PH1;
                    end
                    PH1: begin
                        g_d     = top_bits(wdata);
                        phase_d = PH2;
                    end
                    default: begin
                        commit  = 1'b1;
                        phase_d = PH0;
                    end
                endcase
            end

            if (commit) begin
                commit_entry.index[INDEX_W-1:0] = commit_addr;
                commit_entry.r[COMP_W-1:0]      = r_q;
                commit_entry.g[COMP_W-1:0]      = palette_mode ? g_q : expand3(wdata[2:0]);
                commit_entry.b[COMP_W-1:0]      = palette_mode ? top_bits(wdata) : b_q;
                index_d                         = next_index;
                if (fifo_full && !xfer) begin
                    overflow_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase_q    <= PH0;
            index_q    <= '0;
            r_q        <= '0;
            g_q        <= '0;
            b_q        <= '0;
            overflow_q <= 1'b0;
            mode_q     <= palette_mode;
        end else begin
            phase_q    <= phase_d;
            index_q    <= index_d;
            r_q        <= r_d;
            g_q        <= g_d;
            b_q        <= b_d;
            overflow_q <= overflow_d;
            mode_q     <= palette_mode;
        end
    end

    vdp_palette_fifo #(
        .WIDTH ($bits(pal_entry_t))
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (commit),
        .din       (commit_entry),
        .pop_ready (pal.pal_ready),
        .valid     (fifo_valid),
        .full      (fifo_full),
        .dout      (head)
    );

    assign pal.pal_valid = fifo_valid;
    assign pal.pal_addr  = head.index[INDEX_W-1:0];
    assign pal.pal_r     = head.r[COMP_W-1:0];
    assign pal.pal_g     = head.g[COMP_W-1:0];
    assign pal.pal_b     = head.b[COMP_W-1:0];
    assign overflow      = overflow_q;

    // Entry fields are sized for the widest parameters; the upper bits are
    // always zero here.
    logic unused_head_bits;
    assign unused_head_bits = ^head;

endmodule

// File: tb/tb_vdp_palette_writer.sv
// Self-checking bench for vdp_palette_writer: directed scenarios plus a
// randomized run, all compared against a byte-list / queue reference model.
module tb_vdp_palette_writer;

    localparam int COMP_W  = 5;
    localparam int INDEX_W = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       palette_mode = 1'b1;
    logic       index_set = 1'b0;
    logic [7:0] index_data = 8'h00;
    logic       wr_en = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       overflow;

    vdp_palette_if #(.COMP_W(COMP_W), .INDEX_W(INDEX_W)) pal ();

    vdp_palette_writer #(.COMP_W(COMP_W), .INDEX_W(INDEX_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .palette_mode (palette_mode),
        .index_set    (index_set),
        .index_data   (index_data),
        .wr_en        (wr_en),
        .wdata        (wdata),
        .overflow     (overflow),
        .pal          (pal)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int addr;
        int r;
        int g;
        int b;
    } ent_t;

    ent_t m_fifo[$];
    ent_t m_out[$];
    ent_t d_out[$];
    int   m_bytes[$];
    int   m_idx;
    bit   m_ovf;
    bit   m_mode;

    // Record every transfer the DUT performs at the following rising edge.
    always @(negedge clk) begin
        ent_t e;
        if (reset_n && pal.pal_valid && pal.pal_ready) begin
            e.addr = int'(pal.pal_addr);
            e.r    = int'(pal.pal_r);
            e.g    = int'(pal.pal_g);
            e.b    = int'(pal.pal_b);
            d_out.push_back(e);
        end
    end

    function automatic int exp3(int v);
        int full;
        full = ((v << 5) | (v << 2) | (v >> 1)) & 255;
        return full >> (8 - COMP_W);
    endfunction

    function automatic int comp8(int d);
        return d >> (8 - COMP_W);
    endfunction

    // Reference model: advance by one clock using the inputs now applied.
    task automatic model_clock();
        bit   pop, was_full, commit;
        ent_t e;
        int   need;
        if (!reset_n) begin
            m_fifo.delete();
            m_bytes.delete();
            m_idx  = 0;
            m_ovf  = 0;
            m_mode = palette_mode;
            return;
        end
        was_full = (m_fifo.size() == 2);
        pop      = (m_fifo.size() != 0) && pal.pal_ready;
        commit   = 0;
        if (palette_mode != m_mode) begin
            m_bytes.delete();
            m_mode = palette_mode;
        end
        if (index_set) begin
            m_idx = index_data % (1 << INDEX_W);
            m_bytes.delete();
            m_ovf = 0;
        end else if (wr_en) begin
            m_bytes.push_back(int'(wdata));
            need = m_mode ? 3 : 2;
            if (m_bytes.size() == need) begin
                if (m_mode) begin
                    e.addr = m_idx;
                    e.r = comp8(m_bytes[0]);
                    e.g = comp8(m_bytes[1]);
                    e.b = comp8(m_bytes[2]);
                    m_idx = (m_idx + 1) % (1 << INDEX_W);
                end else begin
                    e.addr = m_idx % 16;
                    e.r = exp3((m_bytes[0] >> 4) & 7);
                    e.b = exp3(m_bytes[0] & 7);
                    e.g = exp3(m_bytes[1] & 7);
                    m_idx = (e.addr + 1) % 16;
                end
                m_bytes.delete();
                commit = 1;
            end
        end
        if (pop) m_out.push_back(m_fifo.pop_front());
        if (commit) begin
            if (was_full && !pop) m_ovf = 1;
            else m_fifo.push_back(e);
        end
    endtask

    task automatic tick();
        model_clock();
        @(posedge clk);
        #1;
        index_set = 1'b0;
        wr_en     = 1'b0;
    endtask

    task automatic write_byte(input int b);
        wdata = 8'(b);
        wr_en = 1'b1;
        tick();
    endtask

    task automatic set_index(input int v);
        index_data = 8'(v);
        index_set  = 1'b1;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_logs();
        d_out.delete();
        m_out.delete();
    endtask

    task automatic test_reset();
        pal.pal_ready = 1'b1;
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        checks++;
        if (pal.pal_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b expected 0", pal.pal_valid);
        end
        checks++;
        if ({pal.pal_addr, pal.pal_r, pal.pal_g, pal.pal_b} !== '0) begin
            errors++; $display("FAIL reset_outputs: got addr=%0d r=%0d g=%0d b=%0d expected all 0",
                               pal.pal_addr, pal.pal_r, pal.pal_g, pal.pal_b);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL reset_overflow: got %b expected 0", overflow);
        end
    endtask

    task automatic test_three_byte_example();
        palette_mode = 1'b1;
        pal.pal_ready = 1'b1;
        set_index(8'h00);
        write_byte(8'h08);
        write_byte(8'hF0);
        write_byte(8'h00);
        checks++;
        if ({pal.pal_valid, pal.pal_addr, pal.pal_r, pal.pal_g, pal.pal_b} !== {1'b1, 8'd0, 5'd1, 5'd30, 5'd0}) begin
            errors++; $display("FAIL rgb3_entry: got v=%b a=%0d r=%0d g=%0d b=%0d expected v=1 a=0 r=1 g=30 b=0",
                               pal.pal_valid, pal.pal_addr, pal.pal_r, pal.pal_g, pal.pal_b);
        end
        idle(1);
        checks++;
        if (pal.pal_valid !== 1'b0) begin
            errors++; $display("FAIL rgb3_single_pulse: got valid=%b expected 0", pal.pal_valid);
        end
        for (int i = 0; i < 3; i++) write_byte($urandom_range(255));
        checks++;
        if (pal.pal_valid !== 1'b1 || pal.pal_addr !== 8'd1) begin
            errors++; $display("FAIL rgb3_next_index: got v=%b a=%0d expected v=1 a=1", pal.pal_valid, pal.pal_addr);
        end
    endtask

    task automatic test_two_byte_example();
        palette_mode = 1'b0;
        idle(1);
        set_index(8'h0F);
        write_byte(8'h75);
        write_byte(8'h03);
        checks++;
        if ({pal.pal_valid, pal.pal_addr, pal.pal_r, pal.pal_g, pal.pal_b} !== {1'b1, 8'd15, 5'b11111, 5'b01101, 5'b10110}) begin
            errors++; $display("FAIL legacy_entry: got v=%b a=%0d r=%b g=%b b=%b expected v=1 a=15 r=11111 g=01101 b=10110",
                               pal.pal_valid, pal.pal_addr, pal.pal_r, pal.pal_g, pal.pal_b);
        end
        write_byte($urandom_range(255));
        write_byte($urandom_range(255));
        checks++;
        if (pal.pal_valid !== 1'b1 || pal.pal_addr !== 8'd0) begin
            errors++; $display("FAIL legacy_wrap: got v=%b a=%0d expected v=1 a=0", pal.pal_valid, pal.pal_addr);
        end
    endtask

    task automatic test_wrap_256();
        palette_mode = 1'b1;
        pal.pal_ready = 1'b1;
        idle(1);
        set_index(8'hFF);
        clear_logs();
        for (int i = 0; i < 256 * 3; i++) write_byte($urandom_range(255));
        idle(3);
        checks++;
        if (d_out.size() != 256 || m_out.size() != 256) begin
            errors++; $display("FAIL wrap_count: got %0d expected 256", d_out.size());
        end
        for (int i = 0; i < d_out.size() && i < m_out.size(); i++) begin
            checks++;
            if ({d_out[i].addr, d_out[i].r, d_out[i].g, d_out[i].b} != {m_out[i].addr, m_out[i].r, m_out[i].g, m_out[i].b}) begin
                errors++; $display("FAIL wrap_entry[%0d]: got a=%0d r=%0d g=%0d b=%0d expected a=%0d r=%0d g=%0d b=%0d", i,
                                   d_out[i].addr, d_out[i].r, d_out[i].g, d_out[i].b,
                                   m_out[i].addr, m_out[i].r, m_out[i].g, m_out[i].b);
            end
        end
        if (d_out.size() == 256) begin
            checks++;
            if (d_out[0].addr != 255 || d_out[1].addr != 0 || d_out[255].addr != 254) begin
                errors++; $display("FAIL wrap_addrs: got first=%0d second=%0d last=%0d expected 255 0 254",
                                   d_out[0].addr, d_out[1].addr, d_out[255].addr);
            end
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL wrap_overflow: got %b expected 0", overflow);
        end
    endtask

    task automatic test_overflow();
        palette_mode = 1'b1;
        pal.pal_ready = 1'b0;
        set_index(8'h10);
        clear_logs();
        for (int i = 0; i < 9; i++) write_byte($urandom_range(255));
        checks++;
        if (overflow !== 1'b1 || pal.pal_valid !== 1'b1 || pal.pal_addr !== 8'h10) begin
            errors++; $display("FAIL ovf_set: got ovf=%b v=%b a=%0d expected ovf=1 v=1 a=16",
                               overflow, pal.pal_valid, pal.pal_addr);
        end
        pal.pal_ready = 1'b1;
        idle(4);
        checks++;
        if (d_out.size() != 2 || m_out.size() != 2) begin
            errors++; $display("FAIL ovf_drain_count: got %0d expected 2", d_out.size());
        end else begin
            checks++;
            if (d_out[0].addr != 16 || d_out[1].addr != 17 ||
                {d_out[0].r, d_out[0].g, d_out[0].b, d_out[1].r, d_out[1].g, d_out[1].b} !=
                {m_out[0].r, m_out[0].g, m_out[0].b, m_out[1].r, m_out[1].g, m_out[1].b}) begin
                errors++; $display("FAIL ovf_drain_order: got a=%0d,%0d expected a=16,17 with model colours",
                                   d_out[0].addr, d_out[1].addr);
            end
        end
        set_index(8'h00);
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL ovf_clear: got %b expected 0", overflow);
        end
        // Full FIFO, head leaves in the same cycle as the third commit.
        clear_logs();
        pal.pal_ready = 1'b0;
        for (int i = 0; i < 8; i++) write_byte($urandom_range(255));
        pal.pal_ready = 1'b1;
        write_byte($urandom_range(255));
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL ovf_same_cycle: got ovf=%b expected 0", overflow);
        end
        idle(4);
        checks++;
        if (d_out.size() != 3 || d_out[0].addr != 0 || d_out[1].addr != 1 || d_out[2].addr != 2) begin
            errors++; $display("FAIL ovf_same_cycle_entries: got count=%0d expected 3 at addr 0,1,2", d_out.size());
        end
    endtask

    task automatic test_index_set_collision();
        palette_mode = 1'b1;
        pal.pal_ready = 1'b1;
        set_index(8'h20);
        clear_logs();
        write_byte($urandom_range(255));
        write_byte($urandom_range(255));
        index_data = 8'h40;
        index_set  = 1'b1;
        wdata      = 8'(($urandom_range(255)));
        wr_en      = 1'b1;
        tick();
        idle(2);
        checks++;
        if (d_out.size() != 0 || pal.pal_valid !== 1'b0) begin
            errors++; $display("FAIL collide_no_entry: got count=%0d v=%b expected 0 0", d_out.size(), pal.pal_valid);
        end
        for (int i = 0; i < 3; i++) write_byte($urandom_range(255));
        idle(2);
        checks++;
        if (d_out.size() != 1 || (d_out.size() == 1 && d_out[0].addr != 8'h40)) begin
            errors++; $display("FAIL collide_next_addr: got count=%0d addr=%0d expected 1 at 64",
                               d_out.size(), (d_out.size() > 0) ? d_out[0].addr : -1);
        end
    endtask

    task automatic test_reset_mid();
        palette_mode = 1'b1;
        pal.pal_ready = 1'b0;
        set_index(5);
        clear_logs();
        for (int i = 0; i < 4; i++) write_byte($urandom_range(255));
        reset_n = 1'b0;
        tick();
        checks++;
        if ({pal.pal_valid, pal.pal_addr, pal.pal_r, pal.pal_g, pal.pal_b, overflow} !== '0) begin
            errors++; $display("FAIL midreset_outputs: got v=%b a=%0d r=%0d g=%0d b=%0d ovf=%b expected all 0",
                               pal.pal_valid, pal.pal_addr, pal.pal_r, pal.pal_g, pal.pal_b, overflow);
        end
        reset_n = 1'b1;
        pal.pal_ready = 1'b1;
        for (int i = 0; i < 3; i++) write_byte($urandom_range(255));
        idle(2);
        checks++;
        if (d_out.size() != 1 || (d_out.size() == 1 && d_out[0].addr != 0)) begin
            errors++; $display("FAIL midreset_after: got count=%0d expected one entry at addr 0", d_out.size());
        end
    endtask

    task automatic test_random();
        clear_logs();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(49) == 0) palette_mode = ~palette_mode;
            index_set  = ($urandom_range(24) == 0);
            index_data = 8'($urandom_range(255));
            wr_en      = ($urandom_range(9) < 7);
            wdata      = 8'($urandom_range(255));
            pal.pal_ready = ($urandom_range(1) == 1);
            tick();
            checks++;
            if (pal.pal_valid !== (m_fifo.size() != 0) || overflow !== m_ovf) begin
                errors++; $display("FAIL rand_flags[%0d]: got v=%b ovf=%b expected v=%b ovf=%b",
                                   c, pal.pal_valid, overflow, m_fifo.size() != 0, m_ovf);
            end
            if (m_fifo.size() != 0) begin
                checks++;
                if ({int'(pal.pal_addr), int'(pal.pal_r), int'(pal.pal_g), int'(pal.pal_b)} !=
                    {m_fifo[0].addr, m_fifo[0].r, m_fifo[0].g, m_fifo[0].b}) begin
                    errors++; $display("FAIL rand_head[%0d]: got a=%0d r=%0d g=%0d b=%0d expected a=%0d r=%0d g=%0d b=%0d",
                                       c, pal.pal_addr, pal.pal_r, pal.pal_g, pal.pal_b,
                                       m_fifo[0].addr, m_fifo[0].r, m_fifo[0].g, m_fifo[0].b);
                end
            end
        end
        pal.pal_ready = 1'b1;
        idle(4);
        checks++;
        if (d_out.size() != m_out.size()) begin
            errors++; $display("FAIL rand_count: got %0d expected %0d", d_out.size(), m_out.size());
        end
        for (int i = 0; i < d_out.size() && i < m_out.size(); i++) begin
            checks++;
            if ({d_out[i].addr, d_out[i].r, d_out[i].g, d_out[i].b} != {m_out[i].addr, m_out[i].r, m_out[i].g, m_out[i].b}) begin
                errors++; $display("FAIL rand_stream[%0d]: got a=%0d expected a=%0d", i, d_out[i].addr, m_out[i].addr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_three_byte_example();
        test_two_byte_example();
        test_wrap_256();
        test_overflow();
        test_index_set_collision();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vdp_palette_writer.md
VDP_PALETTE_WRITER -- requirements
Module: vdp_palette_writer

Interface
REQ-001 SHALL have parameter COMP_W, default 5, meaning output colour component width (legal 3..8).
REQ-002 SHALL have parameter INDEX_W, default 8, meaning palette address width (legal 4..8).
REQ-003 SHALL have port clk  input  1  single clock; the block uses one clock, and reset is synchronous and active-low.
REQ-004 SHALL have port reset_n  input  1  synchronous active-low reset.
REQ-005 SHALL have port palette_mode  input  1  0 = 16-entry 2-byte mode, 1 = full 3-byte mode.
REQ-006 SHALL have port index_set  input  1  one-cycle strobe, R#16 write.
REQ-007 SHALL have port index_data  input  8  new palette index, low INDEX_W bits used.
REQ-008 SHALL have port wr_en  input  1  one-cycle strobe, palette port data write.
REQ-009 SHALL have port wdata  input  8  palette port data byte.
REQ-010 SHALL have port pal_valid  output  1  committed entry available.
REQ-011 SHALL have port pal_ready  input  1  palette RAM accepts the entry.
REQ-012 SHALL have port pal_addr  output  INDEX_W  entry index.
REQ-013 SHALL have port pal_r, pal_g, pal_b  output  COMP_W each  colour components.
REQ-014 SHALL have port overflow  output  1  sticky flag for a dropped entry.

Function
REQ-015 SHALL track a byte phase: PH0, PH1, PH2.
- 2-byte mode: PH0->PH1->PH0.
- 3-byte mode: PH0->PH1->PH2->PH0.
- Each accepted wr_en advances the phase by one step.
REQ-016 In 2-byte mode:
- PH0 byte latches R = wdata[6:4] and B = wdata[2:0].
- PH1 byte supplies G = wdata[2:0] and commits.
- Each 3-bit value expands to COMP_W by left-justifying it and repeating its MSBs into the low bits. Example for COMP_W = 5: 3'b101 becomes 5'b10110.
REQ-017 In 3-byte mode:
- Bytes are R, G, B in order; each component is wdata[7:8-COMP_W].
- The PH2 byte commits.
REQ-018 A commit SHALL capture {index, R, G, B} in the wr_en cycle; the entry SHALL appear at pal_valid on the next cycle if the FIFO was empty (1-cycle latency).
REQ-019 After each commit the index SHALL increment.
- 2-byte mode: wraps 15->0 and uses only the low 4 bits.
- 3-byte mode: wraps (2^INDEX_W-1)->0.
REQ-020 index_set SHALL load the index from index_data and force PH0; partial bytes are discarded.
REQ-021 When index_set and wr_en occur in the same cycle, index_set SHALL win and the wr_en byte SHALL be dropped.
REQ-022 Any change of palette_mode SHALL force PH0; the index is kept.
REQ-023 Committed entries SHALL pass through a 2-entry FIFO.
- An entry transfers when pal_valid && pal_ready.
- Outputs hold stable while pal_valid=1 and pal_ready=0.
REQ-024 On a commit while the FIFO holds 2 entries:
- The new entry SHALL be dropped and overflow set.
- The index SHALL still advance.
- If the head transfers in the same cycle as the commit, the commit SHALL be accepted with no overflow.
REQ-025 overflow SHALL clear only on index_set or reset.

Reset
REQ-026 On reset_n=0 at a clk edge, the block SHALL set:
- phase=PH0, index=0, FIFO empty, pal_valid=0, overflow=0;
- pal_addr, pal_r, pal_g and pal_b = 0.
REQ-027 A reset mid-sequence SHALL discard partial bytes and FIFO contents, and SHALL not emit any entry.

Structure
REQ-028 Package vdp_palette_pkg SHALL hold:
- the phase enum (PH0/PH1/PH2);
- LEGACY_ENTRIES=16;
- the FIFO entry struct {index, r, g, b}.
REQ-029 The 2-entry FIFO SHALL be a sub-module vdp_palette_fifo parameterised by entry width; all other logic stays in vdp_palette_writer.

Verification
REQ-030 3-byte mode, COMP_W=5, pal_ready=1, index_set 0x00, then wdata 0x08, 0xF0, 0x00 -> single pal_valid pulse the cycle after the third byte with addr 0, r=1, g=30, b=0; index becomes 1.
REQ-031 2-byte mode, index_set 0x0F, then wdata 0x75, 0x03 -> addr 15, r=5'b11111, b=5'b10110, g=5'b01101; the next entry goes to addr 0.
REQ-032 3-byte mode, index_set 0xFF, 256 triplets -> 256 entries, addresses 0xFF, 0x00 ... 0xFE in order, overflow=0.
REQ-033 pal_ready=0, 3 commits -> FIFO holds the first two, the third is dropped and overflow=1; raising pal_ready delivers exactly 2 entries in order; index_set clears overflow.
REQ-034 Two bytes written in 3-byte mode, then index_set 0x40 in the same cycle as a wr_en -> no entry emitted, phase=PH0; the next triplet commits at addr 0x40.
REQ-035 reset_n=0 asserted after PH1 with 1 entry pending -> all outputs 0 next cycle; a following triplet commits at addr 0.
